// File: rtl/idli_fetch_decode.sv
// Front end: assembles instruction halfwords (and an optional 16b immediate)
// from the lo/hi SQI nibble streams and presents a decoded op to execute.

package idli_pkg;

   typedef logic [3:0] sqi_data_t;

   typedef struct packed {
      logic       imm;
      logic [2:0] c;
      logic [2:0] b;
      logic [2:0] a;
      logic [1:0] q;
      logic [1:0] p;
   } op_t;

endpackage

module idli_fetch_decode
   import idli_pkg::*;
(
   input  logic      i_clk,
   input  logic      i_rst,
   input  sqi_data_t i_sqi_lo,
   input  sqi_data_t i_sqi_hi,
   input  logic      i_sqi_vld,
   output logic      o_sqi_rdy,
   input  logic      i_flush,
   output logic      o_op_vld,
   input  logic      i_op_rdy,
   output op_t       o_op,
   output logic [15:0] o_imm,
   output logic      o_op_err
);

   typedef enum logic [2:0] {
      ST_INSTR_LO,
      ST_INSTR_HI,
      ST_IMM_LO,
      ST_IMM_HI,
      ST_OUT
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] imm_q, imm_d;
   logic [7:0]  sqi_byte;
   logic        beat;

   function automatic op_t decode(input logic [13:0] instr);
      op_t op;
      op.p   = instr[1:0];
      op.q   = instr[3:2];
      op.a   = instr[6:4];
      op.b   = instr[9:7];
      op.c   = instr[12:10];
      op.imm = instr[13];
      return op;
   endfunction

   assign sqi_byte  = {i_sqi_hi, i_sqi_lo};
   assign o_sqi_rdy = (state_q != ST_OUT);
   assign beat      = i_sqi_vld && o_sqi_rdy;

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      imm_d   = imm_q;
      // A flush wins over everything, including a beat landing this cycle.
      if (i_flush) begin
         state_d = ST_INSTR_LO;
      end else begin
         case (state_q)
            ST_INSTR_LO: begin
               if (beat) begin
                  instr_d[7:0] = sqi_byte;
                  state_d      = ST_INSTR_HI;
               end
            end
            ST_INSTR_HI: begin
               if (beat) begin
                  instr_d[15:8] = sqi_byte;
                  state_d       = sqi_byte[5] ? ST_IMM_LO : ST_OUT;
               end
            end
            ST_IMM_LO: begin
               if (beat) begin
                  imm_d[7:0] = sqi_byte;
                  state_d    = ST_IMM_HI;
               end
            end
            ST_IMM_HI: begin
               if (beat) begin
                  imm_d[15:8] = sqi_byte;
                  state_d     = ST_OUT;
               end
            end
            ST_OUT: begin
               if (i_op_rdy) begin
                  state_d = ST_INSTR_LO;
               end
            end
            default: begin
               state_d = ST_INSTR_LO;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_INSTR_LO;
         instr_q <= '0;
         imm_q   <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         imm_q   <= imm_d;
      end
   end

   // imm_q may hold a stale value from an earlier op; mask it unless imm is set.
   assign o_op_vld = (state_q == ST_OUT);
   assign o_op     = decode(instr_q[13:0]);
   assign o_imm    = instr_q[13] ? imm_q : 16'h0000;
   assign o_op_err = |instr_q[15:14];

endmodule
